// File: rtl/icb2apb_bridge_pkg.sv
// Shared types and constants for the ICB-to-APB bridge.
// State encodings are fixed so that waveforms and debug scripts can decode them.
package icb2apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RSP    = 2'd3
    } state_t;

    localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/icb2apb_bridge.sv
// Single-outstanding ICB slave to APB master bridge with optional PREADY timeout.
// Every output except i_icb_cmd_rdy comes from a register or a decode of the state register.
module icb2apb_bridge
    import icb2apb_bridge_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int USR_W   = 1,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_icb_cmd_vld,
    output logic              i_icb_cmd_rdy,
    input  logic              i_icb_cmd_read,
    input  logic [AW-1:0]     i_icb_cmd_addr,
    input  logic [DW-1:0]     i_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i_icb_cmd_wmask,
    input  logic [USR_W-1:0]  i_icb_cmd_usr,
    output logic              i_icb_rsp_vld,
    input  logic              i_icb_rsp_rdy,
    output logic              i_icb_rsp_err,
    output logic [DW-1:0]     i_icb_rsp_rdata,
    output logic [USR_W-1:0]  i_icb_rsp_usr,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [AW-1:0]     apb_paddr,
    output logic [DW-1:0]     apb_pwdata,
    output logic [DW/8-1:0]   apb_pstrb,
    output logic [2:0]        apb_pprot,
    input  logic              apb_pready,
    input  logic              apb_pslverr,
    input  logic [DW-1:0]     apb_prdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);

    state_t state, state_nxt;

    logic              hold_write;
    logic [AW-1:0]     hold_addr;
    logic [DW-1:0]     hold_wdata;
    logic [DW/8-1:0]   hold_wmask;
    logic [USR_W-1:0]  hold_usr;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rsp_err_q;
    logic [DW-1:0]     rsp_rdata_q;

    logic cmd_hsk;
    logic access_timeout;

    assign cmd_hsk        = i_icb_cmd_vld & i_icb_cmd_rdy;
    // PREADY wins over the timeout when both land in the same cycle.
    assign access_timeout = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT) && !apb_pready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_icb_cmd_vld) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_pready || access_timeout) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_icb_rsp_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        i_icb_cmd_rdy = 1'b0;
        apb_psel      = 1'b0;
        apb_penable   = 1'b0;
        i_icb_rsp_vld = 1'b0;
        case (state)
            ST_IDLE:   i_icb_cmd_rdy = 1'b1;
            ST_SETUP:  apb_psel      = 1'b1;
            ST_ACCESS: begin
                apb_psel    = 1'b1;
                apb_penable = 1'b1;
            end
            ST_RSP:    i_icb_rsp_vld = 1'b1;
            default:   i_icb_cmd_rdy = 1'b0;
        endcase
    end

    // Command holding registers, wait counter and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_write  <= 1'b0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_wmask  <= '0;
            hold_usr    <= '0;
            wait_cnt    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (cmd_hsk) begin
                hold_write <= ~i_icb_cmd_read;
                hold_addr  <= i_icb_cmd_addr;
                hold_wdata <= i_icb_cmd_wdata;
                hold_wmask <= i_icb_cmd_wmask;
                hold_usr   <= i_icb_cmd_usr;
                wait_cnt   <= '0;
            end
            if (state == ST_ACCESS) begin
                if (apb_pready) begin
                    rsp_err_q   <= apb_pslverr;
                    rsp_rdata_q <= (!hold_write && !apb_pslverr) ? apb_prdata : '0;
                end else if (access_timeout) begin
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign apb_pwrite      = hold_write;
    assign apb_paddr       = hold_addr;
    assign apb_pwdata      = hold_wdata;
    // Reads never carry strobes on APB.
    assign apb_pstrb       = hold_write ? hold_wmask : '0;
    assign apb_pprot       = APB_PPROT_DEFAULT;

    assign i_icb_rsp_err   = rsp_err_q;
    assign i_icb_rsp_rdata = rsp_rdata_q;
    assign i_icb_rsp_usr   = hold_usr;

endmodule

// File: tb/tb_icb2apb_bridge.sv
// Bench for icb2apb_bridge: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level reference model.
module tb_icb2apb_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld, cmd_rdy, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        cmd_usr;
    logic        rsp_vld, rsp_rdy, rsp_err;
    logic [31:0] rsp_rdata;
    logic        rsp_usr;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    icb2apb_bridge #(
        .AW(32), .DW(32), .USR_W(1), .TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_vld(cmd_vld), .i_icb_cmd_rdy(cmd_rdy), .i_icb_cmd_read(cmd_read),
        .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
        .i_icb_cmd_usr(cmd_usr),
        .i_icb_rsp_vld(rsp_vld), .i_icb_rsp_rdy(rsp_rdy), .i_icb_rsp_err(rsp_err),
        .i_icb_rsp_rdata(rsp_rdata), .i_icb_rsp_usr(rsp_usr),
        .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
        .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_pstrb(pstrb), .apb_pprot(pprot),
        .apb_pready(pready), .apb_pslverr(pslverr), .apb_prdata(prdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Transaction-level expectation: waits = ACCESS cycles with PREADY low before it rises.
    function automatic void ref_model(input logic rd, input int waits, input logic slverr,
                                      input logic [31:0] prd, output logic err,
                                      output logic [31:0] rdata, output int lat);
        if (TO != 0 && waits > TO) begin
            err = 1'b1; rdata = 32'h0; lat = 3 + TO;
        end else begin
            err = slverr; rdata = (rd && !slverr) ? prd : 32'h0; lat = 3 + waits;
        end
    endfunction

    task automatic run_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic usr, input int waits,
                           input logic slverr, input logic [31:0] prd, input int bp,
                           input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        int cyc;
        int acc;
        @(negedge clk);
        chk("cmd_rdy_idle", cmd_rdy, 1);
        cmd_vld = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wdata;
        cmd_wmask = wmask; cmd_usr = usr; rsp_rdy = (bp == 0);
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("setup_psel", {psel, penable}, 2'b10);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", pwrite, !rd);
        chk("setup_pstrb", pstrb, rd ? 4'h0 : wmask);
        chk("setup_pwdata", pwdata, wdata);
        cyc = 1;
        acc = 0;
        while (!rsp_vld && cyc < 40) begin
            @(negedge clk);
            cyc++;
            pready = 1'b0; pslverr = 1'b0; prdata = ~prd;
            if (!rsp_vld && psel && penable) begin
                pready  = (acc == waits);
                pslverr = slverr && (acc == waits);
                prdata  = (acc == waits) ? prd : ~prd;
                acc++;
            end
        end
        pready = 1'b0; pslverr = 1'b0;
        chk("rsp_latency", cyc, exp_lat);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_usr", rsp_usr, usr);
        chk("rsp_psel_low", {psel, penable}, 2'b00);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_vld, rsp_err, rsp_usr, rsp_rdata}, {1'b1, exp_err, usr, exp_rdata});
            chk("bp_cmd_rdy", cmd_rdy, 0);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("post_hsk", {rsp_vld, cmd_rdy}, 2'b01);
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        usr;
        int          waits;
        logic        slverr;
        logic [31:0] prd;
        int          bp;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic        m_err;
        logic [31:0] m_rdata;
        int          m_lat;
        int          seen;

        tbl[0] = '{1'b0, 32'h40, 32'hA5A5_0001, 4'b0011, 1'b1, 0, 1'b0, 32'h0,         0, 1'b0, 32'h0,         3};
        tbl[1] = '{1'b1, 32'h44, 32'h0000_0000, 4'b1111, 1'b0, 3, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 6};
        tbl[2] = '{1'b1, 32'h48, 32'h0,         4'b1111, 1'b1, 0, 1'b1, 32'hDEAD_BEEF, 0, 1'b1, 32'h0,         3};
        tbl[3] = '{1'b0, 32'h4C, 32'h5555_AAAA, 4'b1111, 1'b0, 1, 1'b1, 32'h0,         0, 1'b1, 32'h0,         4};
        tbl[4] = '{1'b1, 32'h50, 32'h0,         4'b0101, 1'b1, 4, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D, 7};
        tbl[5] = '{1'b1, 32'h54, 32'h0,         4'b0000, 1'b0, 9, 1'b0, 32'h1111_2222, 0, 1'b1, 32'h0,         7};
        tbl[6] = '{1'b1, 32'h58, 32'h0,         4'b1000, 1'b1, 0, 1'b0, 32'h8765_4321, 5, 1'b0, 32'h8765_4321, 3};

        rst = 1'b1; cmd_vld = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wmask = '0; cmd_usr = 1'b0; rsp_rdy = 1'b1; pready = 1'b0; pslverr = 1'b0;
        prdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_cmd_rdy", cmd_rdy, 1);
        chk("reset_apb_ctrl", {psel, penable, pwrite, pprot}, 6'b0);
        chk("reset_apb_data", {paddr, pwdata, pstrb}, 68'h0);
        chk("reset_rsp", {rsp_vld, rsp_err, rsp_usr, rsp_rdata}, 35'h0);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].usr,
                    tbl[i].waits, tbl[i].slverr, tbl[i].prd, tbl[i].bp,
                    tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat);
        end

        // Timeout abort followed by a late PREADY pulse while idle
        run_txn(1'b1, 32'h60, 32'h0, 4'hF, 1'b1, 20, 1'b0, 32'h7777_7777, 0, 1'b1, 32'h0, 7);
        pready = 1'b1; prdata = 32'hFFFF_FFFF;
        @(negedge clk);
        pready = 1'b0;
        chk("late_pready_psel", {psel, penable}, 2'b00);
        @(negedge clk);
        chk("late_pready_idle", {rsp_vld, cmd_rdy}, 2'b01);

        // Reset while in ACCESS: transfer dropped, no response ever issued
        cmd_vld = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h70; cmd_usr = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        @(negedge clk);
        chk("rst_mid_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_apb", {psel, penable}, 2'b00);
        chk("rst_mid_cmd_rdy", cmd_rdy, 1);
        seen = 0;
        pready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_vld || psel) seen++;
        end
        pready = 1'b0;
        chk("rst_mid_no_rsp", seen, 0);

        for (int i = 0; i < 40; i++) begin
            logic        r_rd, r_usr, r_err;
            logic [31:0] r_addr, r_wdata, r_prd;
            logic [3:0]  r_wmask;
            int          r_waits, r_bp;
            r_rd    = 1'($urandom);
            r_usr   = 1'($urandom);
            r_addr  = $urandom & 32'hFFFF_FFFC;
            r_wdata = $urandom;
            r_prd   = $urandom;
            r_wmask = 4'($urandom);
            r_waits = $urandom_range(0, 7);
            r_err   = ($urandom_range(0, 3) == 0);
            r_bp    = $urandom_range(0, 2);
            ref_model(r_rd, r_waits, r_err, r_prd, m_err, m_rdata, m_lat);
            run_txn(r_rd, r_addr, r_wdata, r_wmask, r_usr, r_waits, r_err, r_prd, r_bp,
                    m_err, m_rdata, m_lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
